// File: rtl/data_sram_responder.sv
// Memory-side responder for the CPU data-port sram-like bus: one outstanding
// transaction, fixed programmable latency, byte-lane stores into a word array.
module data_sram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              cap_wr;
  logic [1:0]        cap_size;
  logic [31:0]       cap_addr, cap_wdata;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept, commit;
  logic              t_wr;
  logic [1:0]        t_size;
  logic [31:0]       t_addr, t_wdata;
  logic [3:0]        lanes;
  logic              bad;
  logic [ADDR_W-1:0] idx;

  assign addr_ok = resetn & (state == IDLE);
  assign data_ok = (state == RESP);
  assign accept  = req & addr_ok;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        cnt_nx = 4'(LATENCY - 1);
        if (LATENCY == 1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY==1 the commit edge is the accept edge, so the live bus
  // fields are used in IDLE; otherwise the captured copy is used.
  always_comb begin
    t_wr    = (state == IDLE) ? wr    : cap_wr;
    t_size  = (state == IDLE) ? size  : cap_size;
    t_addr  = (state == IDLE) ? addr  : cap_addr;
    t_wdata = (state == IDLE) ? wdata : cap_wdata;
    lanes   = 4'b0000;
    case (t_size)
      2'b00:   lanes = 4'b0001 << t_addr[1:0];
      2'b01:   lanes = t_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    bad = (t_size == 2'b11)
        | ((t_size == 2'b01) & t_addr[0])
        | ((t_size == 2'b10) & (t_addr[1:0] != 2'b00))
        | ((t_addr >> (ADDR_W + 2)) != '0);
    idx = t_addr[ADDR_W+1:2];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_wr    <= 1'b0;
      cap_size  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        cap_wr    <= wr;
        cap_size  <= size;
        cap_addr  <= addr;
        cap_wdata <= wdata;
      end
      if (commit) begin
        if (bad) begin
          rdata <= '0;
          err   <= 1'b1;
        end else begin
          err   <= 1'b0;
          rdata <= t_wr ? '0 : mem[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit & resetn & t_wr & ~bad) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (lanes[k]) mem[idx][8*k +: 8] <= t_wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: a LATENCY=2 and a LATENCY=1 instance driven
// on a shared bus with separate req lines; responses checked from a scoreboard.
module tb_data_sram_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_a, req_b;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        aok_a, dok_a, err_a;
  logic        aok_b, dok_b, err_b;
  logic [31:0] rd_a, rd_b;

  typedef struct {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .resetn(resetn), .req(req_a), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(aok_a), .data_ok(dok_a),
    .rdata(rd_a), .err(err_a)
  );

  data_sram_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr), .size(size),
    .addr(addr), .wdata(wdata), .addr_ok(aok_b), .data_ok(dok_b),
    .rdata(rd_b), .err(err_b)
  );

  // sel=0 targets dut_a, sel=1 targets dut_b; hold keeps req high until data_ok
  task automatic txn(input bit sel, input bit w, input logic [1:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input bit exp_err, input bit hold);
    bit   got;
    int   lat;
    int   exp_lat;
    exp_t e;
    exp_lat = sel ? LAT_B : LAT_A;
    @(negedge clk);
    wr = w; size = sz; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((sel ? aok_b : aok_a) === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL accept_timeout addr=%h: addr_ok never seen, required 1", a);
      req_a = 1'b0; req_b = 1'b0;
      return;
    end
    e.rd = exp_rd; e.er = exp_err;
    sb.push_back(e);
    @(posedge clk);
    if (!hold) begin #1; req_a = 1'b0; req_b = 1'b0; end
    lat = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if ((sel ? dok_b : dok_a) === 1'b1) begin got = 1'b1; break; end
      total++;
      if ((sel ? aok_b : aok_a) !== 1'b0) begin
        bad++;
        $display("FAIL addr_ok_in_wait addr=%h: got %b, required 0", a, sel ? aok_b : aok_a);
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL resp_timeout addr=%h: data_ok never seen, required 1", a);
      req_a = 1'b0; req_b = 1'b0;
      return;
    end
    if (lat != exp_lat) begin
      bad++;
      $display("FAIL latency addr=%h: got %0d, required %0d", a, lat, exp_lat);
    end
    total++;
    if ((sel ? aok_b : aok_a) !== 1'b0) begin
      bad++;
      $display("FAIL addr_ok_in_resp addr=%h: got %b, required 0", a, sel ? aok_b : aok_a);
    end
    e = sb.pop_front();
    total++;
    if ((sel ? rd_b : rd_a) !== e.rd) begin
      bad++;
      $display("FAIL rdata addr=%h: got %h, required %h", a, sel ? rd_b : rd_a, e.rd);
    end
    total++;
    if ((sel ? err_b : err_a) !== e.er) begin
      bad++;
      $display("FAIL err addr=%h: got %b, required %b", a, sel ? err_b : err_a, e.er);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    total++;
    if ((sel ? dok_b : dok_a) !== 1'b0 || (sel ? aok_b : aok_a) !== 1'b1) begin
      bad++;
      $display("FAIL after_resp addr=%h: data_ok=%b addr_ok=%b, required 0 1",
               a, sel ? dok_b : dok_a, sel ? aok_b : aok_a);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_a = 1'b1; req_b = 1'b1;
    wr = 1'b0; size = 2'b10; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({aok_a, dok_a, err_a, aok_b, dok_b, err_b} !== 6'b0 || rd_a !== '0 || rd_b !== '0) begin
      bad++;
      $display("FAIL reset_outputs: aok=%b%b dok=%b%b err=%b%b rd=%h/%h, required all 0",
               aok_a, aok_b, dok_a, dok_b, err_a, err_b, rd_a, rd_b);
    end
    req_a = 1'b0; req_b = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (aok_a !== 1'b1 || aok_b !== 1'b1 || dok_a !== 1'b0 || dok_b !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: aok=%b%b dok=%b%b, required 11 00", aok_a, aok_b, dok_a, dok_b);
    end
  endtask

  task automatic test_word();
    txn(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1);
    txn(0, 0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
  endtask

  task automatic test_lanes();
    txn(0, 1, 2'b10, 32'h10, 32'h11223344, 32'h0, 0, 0);
    txn(0, 1, 2'b00, 32'h13, 32'h5A5A5A5A, 32'h0, 0, 0);
    txn(0, 0, 2'b10, 32'h10, 32'h0, 32'h5A223344, 0, 1);
    txn(0, 1, 2'b10, 32'h10, 32'h00000000, 32'h0, 0, 0);
    txn(0, 1, 2'b01, 32'h12, 32'hBEEFBEEF, 32'h0, 0, 0);
    txn(0, 0, 2'b10, 32'h10, 32'h0, 32'hBEEF0000, 0, 0);
  endtask

  task automatic test_errors();
    txn(0, 1, 2'b01, 32'h11, 32'h12121212, 32'h0, 1, 0);
    txn(0, 1, 2'b10, 32'h12, 32'h34343434, 32'h0, 1, 0);
    txn(0, 1, 2'b11, 32'h10, 32'h56565656, 32'h0, 1, 0);
    txn(0, 0, 2'b11, 32'h10, 32'h0, 32'h0, 1, 0);
    txn(0, 0, 2'b10, 32'h10, 32'h0, 32'hBEEF0000, 0, 0);
    txn(0, 0, 2'b10, 32'h0000_1000, 32'h0, 32'h0, 1, 0);
  endtask

  task automatic test_latency_one();
    txn(1, 1, 2'b10, 32'h40, 32'h12345678, 32'h0, 0, 1);
    txn(1, 0, 2'b10, 32'h40, 32'h0, 32'h12345678, 0, 0);
    txn(1, 1, 2'b00, 32'h41, 32'h99999999, 32'h0, 0, 0);
    txn(1, 0, 2'b10, 32'h40, 32'h0, 32'h12349978, 0, 1);
    txn(1, 1, 2'b01, 32'h43, 32'h77777777, 32'h0, 1, 0);
    txn(1, 0, 2'b10, 32'h40, 32'h0, 32'h12349978, 0, 0);
  endtask

  task automatic test_reset_abort();
    bit seen;
    txn(0, 1, 2'b10, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
    @(negedge clk);
    wr = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h0BADF00D; req_a = 1'b1;
    @(posedge clk);
    #1; req_a = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    total++;
    if (aok_a !== 1'b0 || dok_a !== 1'b0 || rd_a !== '0 || err_a !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: aok=%b dok=%b rd=%h err=%b, required 0 0 0 0",
               aok_a, dok_a, rd_a, err_a);
    end
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dok_a === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL aborted_resp: data_ok=1 seen, required 0");
    end
    txn(0, 0, 2'b10, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_errors();
    test_latency_one();
    test_reset_abort();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
